// File: rtl/instr_encoder_loader.sv
// Purpose: encodes symbolic op requests into 24-bit instruction words and writes them to imem at an auto-incrementing address.
// Latency: handshake at edge N -> err pulse in cycle N+1 or imem_we in cycle N+2; in_ready returns in cycle N+3.
// Backpressure: in_ready=0 while a request is in flight, and stays 0 once DEPTH words are written (until clear/rst).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous restart: address/count/full/err_code to 0, in-flight request dropped
//   in_valid, in_ready  request handshake
//   op_sel, use_imm, rd, rn, rm, imm   symbolic request fields
//   imem_we, imem_addr, imem_wdata     instruction memory write port
//   full, word_count    fill status
//   err, err_code       rejection pulse and sticky reason (01 illegal op, 10 immediate out of range)
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic              use_imm,
    input  logic [3:0]        rd,
    input  logic [3:0]        rn,
    input  logic [3:0]        rm,
    input  logic [15:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [23:0]       imem_wdata,
    output logic              full,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t      state;
    logic [2:0]  op_q;
    logic        use_imm_q;
    logic [3:0]  rd_q;
    logic [3:0]  rn_q;
    logic [3:0]  rm_q;
    logic [11:0] imm_q;    // only the low 12 bits ever reach the word
    logic [1:0]  in_code;

    // Rejection reason for a request; illegal op outranks range error.
    function automatic logic [1:0] check_req(input logic [2:0] op, input logic u,
                                             input logic [15:0] iv);
        logic fits8;
        logic fits12;
        // A value fits N bits signed when all bits above bit N-2 match the sign.
        fits8  = (iv[15:7]  == '0) || (iv[15:7]  == '1);
        fits12 = (iv[15:11] == '0) || (iv[15:11] == '1);
        if (op > 3'd5)
            return 2'b01;
        else if (op == 3'd3 || op == 3'd4)
            return fits12 ? 2'b00 : 2'b10;
        else if (op == 3'd5 || u)
            return fits8 ? 2'b00 : 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic [23:0] encode(input logic [2:0] op, input logic u,
                                           input logic [3:0] d, input logic [3:0] n,
                                           input logic [3:0] m, input logic [11:0] iv);
        logic [3:0]  opc;
        logic [11:0] fld;
        opc = 4'h0;
        fld = {8'h00, m};
        case (op)
            3'd0: opc = u ? 4'h1 : 4'h0;
            3'd1: opc = u ? 4'h3 : 4'h2;
            3'd2: opc = u ? 4'hF : 4'h4;
            3'd3: begin opc = 4'h5; fld = iv;                end
            3'd4: begin opc = 4'h6; fld = iv;                end
            3'd5: begin opc = 4'h7; fld = {4'h0, iv[7:0]};   end
            default: ;
        endcase
        // Immediate forms of the arithmetic ops swap rm for imm8.
        if (u && op <= 3'd2)
            fld = {4'h0, iv[7:0]};
        return {opc, d, n, fld};
    endfunction

    // The range check runs on the raw inputs at the handshake edge so that
    // err is a registered pulse coinciding with the CHECK cycle.
    assign in_code = check_req(op_sel, use_imm, imm);

    // Gated by rst so the encoder is never advertised ready while held in reset.
    assign in_ready = (state == IDLE) && !full && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            use_imm_q  <= 1'b0;
            rd_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            imm_q      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            full       <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else if (clear) begin
            state      <= IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            full       <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    err     <= 1'b0;
                    imem_we <= 1'b0;
                    if (in_valid && in_ready) begin
                        op_q      <= op_sel;
                        use_imm_q <= use_imm;
                        rd_q      <= rd;
                        rn_q      <= rn;
                        rm_q      <= rm;
                        imm_q     <= imm[11:0];
                        if (in_code != 2'b00) begin
                            err      <= 1'b1;
                            err_code <= in_code;
                        end
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err <= 1'b0;
                    // err high here means this request was rejected.
                    if (err) begin
                        state <= IDLE;
                    end else begin
                        imem_wdata <= encode(op_q, use_imm_q, rd_q, rn_q, rm_q, imm_q);
                        imem_addr  <= word_count[ADDR_W-1:0];
                        imem_we    <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    imem_we    <= 1'b0;
                    word_count <= word_count + 1'b1;
                    full       <= (word_count + 1'b1) == DEPTH_W;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op_sel = '0;
    logic        use_imm = 1'b0;
    logic [3:0]  rd = '0, rn = '0, rm = '0;
    logic [15:0] imm = '0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [23:0] imem_wdata;
    logic        full;
    logic [8:0]  word_count;
    logic        err;
    logic [1:0]  err_code;

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .use_imm(use_imm), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .full(full), .word_count(word_count), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: expected events keyed by cycle number, plus fill status.
    logic [23:0] exp_data[int];
    logic [7:0]  exp_addr[int];
    bit          exp_err[int];
    int          m_addr = 0;
    int          m_count = 0;
    logic [1:0]  m_err_code = 2'b00;
    logic [23:0] last_data = '0;
    logic [7:0]  last_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Model: what the encoder must do with a request, from the ISA tables.
    function automatic logic [1:0] m_code(input logic [2:0] op, input logic u, input logic [15:0] iv);
        int v;
        int lo, hi;
        v = int'($signed(iv));
        if (op > 3'd5) return 2'b01;
        if (op == 3'd3 || op == 3'd4) begin lo = -2048; hi = 2047; end
        else if (op == 3'd5 || u)     begin lo = -128;  hi = 127;  end
        else return 2'b00;
        return (v < lo || v > hi) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [23:0] m_word(input logic [2:0] op, input logic u, input logic [3:0] d,
                                           input logic [3:0] n, input logic [3:0] m, input logic [15:0] iv);
        logic [3:0] reg_opc [0:5];
        logic [3:0] imm_opc [0:5];
        logic [11:0] operand;
        reg_opc = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7};
        imm_opc = '{4'h1, 4'h3, 4'hF, 4'h5, 4'h6, 4'h7};
        if (op == 3'd3 || op == 3'd4) operand = iv[11:0];
        else if (op == 3'd5 || u)     operand = {4'h0, iv[7:0]};
        else                          operand = {8'h00, m};
        return {(u ? imm_opc[op] : reg_opc[op]), d, n, operand};
    endfunction

    // Per-cycle comparison of the strobes against the model's expected events.
    always @(negedge clk) begin
        if (!rst) begin
            chk("imem_we", imem_we, exp_data.exists(cyc) ? 1 : 0);
            chk("err", err, exp_err.exists(cyc) ? 1 : 0);
            if (imem_we && exp_data.exists(cyc)) begin
                chk("imem_wdata", imem_wdata, exp_data[cyc]);
                chk("imem_addr", imem_addr, exp_addr[cyc]);
            end
            if (imem_we) begin
                last_data = imem_wdata;
                last_addr = imem_addr;
            end
        end
    end

    task automatic status_chk(input string tag);
        chk({tag, "_word_count"}, word_count, m_count);
        chk({tag, "_full"}, full, (m_count == 4) ? 1 : 0);
        chk({tag, "_err_code"}, err_code, m_err_code);
    endtask

    // mode 0: normal; 1: clear during CHECK; 2: rst during WRITE
    task automatic send(input logic [2:0] op, input logic u, input logic [3:0] d, input logic [3:0] n,
                        input logic [3:0] m, input logic [15:0] iv, input int mode);
        int w;
        int k;
        logic [1:0] code;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1; op_sel = op; use_imm = u; rd = d; rn = n; rm = m; imm = iv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = cyc;
        code = m_code(op, u, iv);
        if (mode == 1) begin
            clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
            m_addr = 0; m_count = 0; m_err_code = 2'b00;
        end else if (mode == 2) begin
            @(posedge clk); #1;
            chk("we_before_rst", imem_we, 1);
            #1 rst = 1'b1;
            #1;
            chk("rst_we", imem_we, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_wdata", imem_wdata, 0);
            chk("rst_count", word_count, 0);
            chk("rst_ready", in_ready, 0);
            chk("rst_errs", {err, err_code, full}, 0);
            m_addr = 0; m_count = 0; m_err_code = 2'b00;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk); #1;
            chk("ready_after_rst", in_ready, 1);
            return;
        end else if (code != 2'b00) begin
            exp_err[k] = 1'b1;
            m_err_code = code;
        end else begin
            exp_data[k+1] = m_word(op, u, d, n, m, iv);
            exp_addr[k+1] = 8'(m_addr);
            m_addr++;
            m_count++;
        end
        @(posedge clk);
        @(posedge clk); #1;
        status_chk("post");
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_addr = 0; m_count = 0; m_err_code = 2'b00;
        chk("clr_addr", imem_addr, 0);
        chk("clr_ready", in_ready, 1);
        status_chk("clr");
    endtask

    initial begin
        // Hand-computed words pin the model itself.
        chk("model_add_imm", m_word(3'd2, 1'b1, 4'd3, 4'd1, 4'd0, 16'hFFFB), 24'hF310FB);
        chk("model_mul_reg", m_word(3'd0, 1'b0, 4'd1, 4'd2, 4'd3, 16'h0000), 24'h012003);
        chk("model_div_range", m_code(3'd1, 1'b1, 16'd200), 2'b10);
        chk("model_illegal_prio", m_code(3'd6, 1'b0, 16'd5000), 2'b01);

        // Reset state.
        #2;
        chk("rst_state", {imem_we, full, err, err_code, in_ready}, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_wdata", imem_wdata, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_first_cycle", in_ready, 1);

        // Directed encodes.
        send(3'd2, 1'b1, 4'd3, 4'd1, 4'd0, 16'hFFFB, 0);
        chk("add_imm_word", last_data, 24'hF310FB); chk("add_imm_addr", last_addr, 0);
        send(3'd0, 1'b0, 4'd1, 4'd2, 4'd3, 16'h0000, 0);
        chk("mul_reg_word", last_data, 24'h012003); chk("mul_reg_addr", last_addr, 1);
        send(3'd3, 1'b0, 4'd2, 4'd4, 4'd0, 16'd2047, 0);
        chk("ldr_word", last_data, 24'h5247FF); chk("ldr_addr", last_addr, 2);

        // Range errors and illegal op.
        send(3'd1, 1'b1, 4'd1, 4'd1, 4'd0, 16'd200, 0);
        chk("div_range_code", err_code, 2'b10);
        send(3'd4, 1'b0, 4'd7, 4'd8, 4'd0, 16'hF7FF, 0);
        chk("str_range_code", err_code, 2'b10);
        send(3'd6, 1'b0, 4'd1, 4'd1, 4'd0, 16'd5000, 0);
        chk("illegal_code", err_code, 2'b01);

        // Lowest legal imm12; fourth word fills DEPTH=4.
        send(3'd4, 1'b0, 4'd7, 4'd8, 4'd0, 16'hF800, 0);
        chk("str_min_word", last_data, 24'h678800); chk("str_min_addr", last_addr, 3);
        chk("full_ready", in_ready, 0);

        // A fifth request is held off.
        @(negedge clk);
        in_valid = 1'b1; op_sel = 3'd2; use_imm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("held_off_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        status_chk("held");

        // clear restarts at address 0.
        do_clear();
        send(3'd5, 1'b0, 4'd0, 4'd0, 4'd0, 16'hFFFF, 0);
        chk("b_word", last_data, 24'h7000FF); chk("b_addr", last_addr, 0);

        // clear during CHECK aborts the write.
        do_clear();
        send(3'd2, 1'b0, 4'd5, 4'd6, 4'd7, 16'h0000, 1);
        @(posedge clk); @(posedge clk); #1;
        status_chk("abort");
        send(3'd2, 1'b0, 4'd5, 4'd6, 4'd7, 16'h0000, 0);
        chk("after_abort_word", last_data, 24'h456007); chk("after_abort_addr", last_addr, 0);

        // rst during WRITE, then a fresh write lands at address 0.
        send(3'd0, 1'b1, 4'd1, 4'd1, 4'd0, 16'h007F, 2);
        status_chk("after_rst");
        send(3'd0, 1'b1, 4'd1, 4'd1, 4'd0, 16'h007F, 0);
        chk("mul_imm_word", last_data, 24'h11107F); chk("mul_imm_addr", last_addr, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
